// File: rtl/updown_rate_counter.sv
// Up/down LED counter with a selectable step rate and wrap, saturate, bounce and freeze modes.
// All switch inputs are synchronised into the clk domain before use.
module updown_rate_counter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MIN_VAL     = 0,
  parameter int unsigned MAX_VAL     = 255,
  parameter int unsigned DIV0        = 40_000_000,
  parameter int unsigned DIV1        = 20_000_000,
  parameter int unsigned DIV2        = 10_000_000,
  parameter int unsigned DIV3        = 5_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic [1:0]       rate,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             dir,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);
  localparam int unsigned      SW    = 7;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'd0,
    MODE_SAT    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FREEZE = 2'd3
  } mode_t;

  logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
  logic [SW-1:0]    sync_out;
  logic             up_s, down_s, clr_s;
  logic [1:0]       rate_s;
  mode_t            mode_s;
  logic [31:0]      div_sel;
  logic [31:0]      pre_cnt;
  logic             tick_int;
  logic             cmd_up, cmd_down;
  logic [WIDTH-1:0] count_nxt;
  logic             dir_nxt;

  // All seven switch bits travel together through one shift chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {up, down, rate, mode, clr}};
    end
  end

  assign sync_out                 = sync_q[SYNC_STAGES-1];
  assign {up_s, down_s, rate_s}   = sync_out[6:3];
  assign mode_s                   = mode_t'(sync_out[2:1]);
  assign clr_s                    = sync_out[0];

  always_comb begin
    div_sel = 32'(DIV0);
    case (rate_s)
      2'd0:    div_sel = 32'(DIV0);
      2'd1:    div_sel = 32'(DIV1);
      2'd2:    div_sel = 32'(DIV2);
      default: div_sel = 32'(DIV3);
    endcase
  end

  // A ">=" compare lets a switch to a shorter period tick at once instead of wrapping pre_cnt.
  assign tick_int = (pre_cnt >= (div_sel - 32'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (clr_s || tick_int) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 32'd1;
    end
  end

  assign cmd_up   = up_s & ~down_s;
  assign cmd_down = down_s & ~up_s;

  always_comb begin
    count_nxt = count;
    dir_nxt   = dir;
    case (mode_s)
      MODE_WRAP, MODE_SAT: begin
        if (cmd_up) begin
          dir_nxt = 1'b1;
          if (count == MAX_C) count_nxt = (mode_s == MODE_WRAP) ? MIN_C : MAX_C;
          else                count_nxt = count + ONE_C;
        end else if (cmd_down) begin
          dir_nxt = 1'b0;
          if (count == MIN_C) count_nxt = (mode_s == MODE_WRAP) ? MAX_C : MIN_C;
          else                count_nxt = count - ONE_C;
        end
      end
      MODE_BOUNCE: begin
        // Either command only enables motion; the dir register picks the way.
        if (cmd_up || cmd_down) begin
          if (dir) begin
            if (count == MAX_C) begin
              count_nxt = MAX_C - ONE_C;
              dir_nxt   = 1'b0;
            end else begin
              count_nxt = count + ONE_C;
            end
          end else begin
            if (count == MIN_C) begin
              count_nxt = MIN_C + ONE_C;
              dir_nxt   = 1'b1;
            end else begin
              count_nxt = count - ONE_C;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= MIN_C;
      dir   <= 1'b1;
      step  <= 1'b0;
    end else begin
      step <= tick_int & ~clr_s;
      if (clr_s) begin
        count <= MIN_C;
        dir   <= 1'b1;
      end else if (tick_int) begin
        count <= count_nxt;
        dir   <= dir_nxt;
      end
    end
  end

  assign at_max = (count == MAX_C);
  assign at_min = (count == MIN_C);

endmodule

// File: tb/tb_updown_rate_counter.sv
// Directed bench for updown_rate_counter: a table of per-step vectors plus hand-written
// sequences for rate change, clear-versus-tick and asynchronous reset.
module tb_updown_rate_counter;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       up   = 1'b0;
  logic       down = 1'b0;
  logic       clr  = 1'b0;
  logic [1:0] rate = 2'd0;
  logic [1:0] mode = 2'd0;
  logic [3:0] count;
  logic       step, dir, at_max, at_min;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       u;
    logic       d;
    logic [1:0] r;
    logic [1:0] m;
    logic [3:0] cnt;
    logic       dr;
    int         period;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  updown_rate_counter #(
    .WIDTH(4), .MIN_VAL(2), .MAX_VAL(12),
    .DIV0(4), .DIV1(3), .DIV2(2), .DIV3(8), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .rate(rate), .mode(mode), .clr(clr),
    .count(count), .step(step), .dir(dir), .at_max(at_max), .at_min(at_min)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void addRow(input logic u, input logic d, input logic [1:0] r,
                                 input logic [1:0] m, input int cnt, input logic dr,
                                 input int period);
    vec_t v;
    v.u = u; v.d = d; v.r = r; v.m = m;
    v.cnt = 4'(cnt); v.dr = dr; v.period = period;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic u, input logic d, input logic [1:0] r, input logic [1:0] m);
    up = u; down = d; rate = r; mode = m;
  endtask

  task automatic waitStep(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!step && cycles < 40);
    checkOutput("step_seen", 32'(step), 32'd1);
  endtask

  // Hold clr long enough to take effect, then release it on a falling edge.
  task automatic restartWith(input logic u, input logic d, input logic [1:0] r, input logic [1:0] m);
    applyStimulus(u, d, r, m);
    clr = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("clr_hold_count", 32'(count), 32'd2);
    checkOutput("clr_hold_step", 32'(step), 32'd0);
    clr = 1'b0;
  endtask

  initial begin
    int cyc;
    logic exp_step;

    for (int i = 0; i < 10; i++) addRow(1, 0, 0, 0, 3 + i, 1, 4);
    addRow(1, 0, 0, 0, 2, 1, 4);
    addRow(1, 0, 0, 0, 3, 1, 4);
    addRow(1, 0, 0, 0, 4, 1, 4);
    addRow(0, 1, 0, 1, 3, 0, 4);
    for (int i = 0; i < 3; i++) addRow(0, 1, 0, 1, 2, 0, 4);
    addRow(0, 1, 0, 0, 12, 0, 4);
    for (int i = 0; i < 5; i++) addRow(0, 1, 0, 0, 11 - i, 0, 4);
    for (int i = 0; i < 5; i++) addRow(1, 1, 1, 0, 7, 0, 3);
    for (int i = 0; i < 5; i++) addRow(1, 0, 1, 3, 7, 0, 3);
    for (int i = 0; i < 3; i++) addRow(1, 0, 1, 0, 8 + i, 1, 3);
    addRow(1, 0, 2, 2, 11, 1, 3);
    addRow(1, 0, 2, 2, 12, 1, 2);
    for (int i = 0; i < 10; i++) addRow(1, 0, 2, 2, 11 - i, 0, 2);
    addRow(1, 0, 2, 2, 3, 1, 2);
    addRow(1, 0, 2, 2, 4, 1, 2);

    applyStimulus(1, 0, 0, 0);
    #12;
    checkOutput("reset_count", 32'(count), 32'd2);
    checkOutput("reset_dir", 32'(dir), 32'd1);
    checkOutput("reset_step", 32'(step), 32'd0);
    checkOutput("reset_at_min", 32'(at_min), 32'd1);
    checkOutput("reset_at_max", 32'(at_max), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].u, vecs[i].d, vecs[i].r, vecs[i].m);
      waitStep(cyc);
      checkOutput($sformatf("row%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      checkOutput($sformatf("row%0d_dir", i), 32'(dir), 32'(vecs[i].dr));
      checkOutput($sformatf("row%0d_at_max", i), 32'(at_max), 32'(vecs[i].cnt == 4'd12));
      checkOutput($sformatf("row%0d_at_min", i), 32'(at_min), 32'(vecs[i].cnt == 4'd2));
      if (vecs[i].period != 0)
        checkOutput($sformatf("row%0d_period", i), 32'(cyc), 32'(vecs[i].period));
    end

    // Slow rate with pre_cnt at 5, then drop to the 2-cycle rate: step after edge 8, 10, 12.
    restartWith(0, 0, 2'd3, 2'd3);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_step = (k == 8) || (k == 10) || (k == 12);
      checkOutput($sformatf("ratechg_step_e%0d", k), 32'(step), 32'(exp_step));
      if (k == 5) rate = 2'd2;
    end
    checkOutput("ratechg_count", 32'(count), 32'd2);

    // clr lands on the same edge as a tick and must win without a step.
    restartWith(0, 1, 2'd0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      waitStep(cyc);
      checkOutput($sformatf("clrseq_count%0d", i), 32'(count), 32'(12 - i));
    end
    checkOutput("clrseq_dir_before", 32'(dir), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("clrtick_step_e%0d", k), 32'(step), 32'd0);
      checkOutput($sformatf("clrtick_count_e%0d", k), 32'(count), (k == 4) ? 32'd2 : 32'd9);
    end
    checkOutput("clrtick_dir", 32'(dir), 32'd1);

    clr = 1'b0;
    waitStep(cyc);
    checkOutput("prereset_count", 32'(count), 32'd12);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("asyncrst_count", 32'(count), 32'd2);
    checkOutput("asyncrst_step", 32'(step), 32'd0);
    checkOutput("asyncrst_dir", 32'(dir), 32'd1);
    checkOutput("asyncrst_at_min", 32'(at_min), 32'd1);
    checkOutput("asyncrst_at_max", 32'(at_max), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
